// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and the output-buffer entry type for the RAM-backed FIFO controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF / DEPTH_DEF : default geometry
//   BUF_DATA_MAX : widest word the output buffer entry can carry
//   buf_entry_t  : one output-buffer slot (data, valid)
//   make_entry   : builds a valid entry from a (zero-extended) word
package ram_fifo_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DEPTH_DEF      = 1024;

  // Entry data field is sized for the widest supported word; narrower words
  // are zero-extended on the way in and sliced on the way out.
  localparam int BUF_DATA_MAX = 64;
  localparam int BUF_ENTRIES  = 2;

  typedef struct packed {
    logic [BUF_DATA_MAX-1:0] data;
    logic                    valid;
  } buf_entry_t;

  function automatic buf_entry_t make_entry(input logic [BUF_DATA_MAX-1:0] d);
    buf_entry_t e;
    e.data  = d;
    e.valid = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/ram_fifo_outbuf.sv
// Two-entry output buffer holding words returned by the RAM; slot 0 is the FIFO head.
// Latency: a word written at edge N is on out_data after edge N (registered head).
// Backpressure: caller must only write when a slot is free (occ + in-flight <= 2).
//
// Ports:
//   clk, rst (async, active-low), flush (sync clear)
//   wr_vld / wr_dat : word arriving from RAM this cycle
//   pop             : head consumed at this edge
//   out_valid / out_data : registered head entry
//   occ             : number of valid entries (0..2)
module ram_fifo_outbuf
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_vld,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occ
);

  buf_entry_t ent_q [BUF_ENTRIES];
  buf_entry_t ent_d [BUF_ENTRIES];
  logic       pop_ok;

  assign pop_ok = pop && ent_q[0].valid;

  // Pop shifts slot 1 into the head first, so a same-cycle write lands in
  // whichever slot is free after the shift and order is preserved.
  always_comb begin
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    if (pop_ok) begin
      ent_d[0] = ent_q[1];
      ent_d[1] = '0;
    end
    if (wr_vld) begin
      if (!ent_d[0].valid) begin
        ent_d[0] = make_entry(BUF_DATA_MAX'(wr_dat));
      end else begin
        ent_d[1] = make_entry(BUF_DATA_MAX'(wr_dat));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else if (flush) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end

  assign out_valid = ent_q[0].valid;
  assign out_data  = ent_q[0].data[DATA_WIDTH-1:0];
  assign occ       = {1'b0, ent_q[0].valid} + {1'b0, ent_q[1].valid};

  // Padding bits above DATA_WIDTH are always zero and never leave the block.
  if (DATA_WIDTH < BUF_DATA_MAX) begin : g_pad
    logic unused_pad;
    assign unused_pad = |ent_q[0].data[BUF_DATA_MAX-1:DATA_WIDTH];
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external single-clock RAM with a 2-entry registered output buffer.
// Latency: word pushed at edge N into an empty FIFO is valid on out_data after edge N+2.
// Backpressure: in_ready drops when full or flushing; reads prefetch until buffer + in-flight reach 2.
//
// Ports:
//   clk, rst (async, active-low), flush (sync clear of all contents)
//   in_valid / in_ready / in_data    : upstream valid-ready
//   out_valid / out_ready / out_data : downstream valid-ready, head word registered
//   count, full, empty               : occupancy (RAM + in-flight + output buffer)
//   ram_write_addr/enable, ram_data_in, ram_read_addr/enable, ram_data_out : RAM port
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  ram_write_enable,
  output logic                  ram_read_enable,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;   // words written to RAM but not yet read
  logic [ADDR_WIDTH:0]   count_q;
  logic                  rd_inflight;
  logic                  push;
  logic                  pop;
  logic                  rd_en;
  logic [1:0]            buf_occ;
  logic [2:0]            pend;

  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = rst && !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Read only if the buffer will still have a free slot when the data lands.
  // ram_cnt is the pre-edge value, so a word written this cycle is never read
  // in the same cycle. Written as pend < 2 + pop to avoid unsigned underflow.
  assign pend  = {1'b0, buf_occ} + {2'b0, rd_inflight};
  assign rd_en = rst && !flush && (ram_cnt != '0) && (pend < (3'd2 + {2'b0, pop}));

  assign ram_write_enable = push;
  assign ram_write_addr   = wr_ptr;
  assign ram_data_in      = in_data;
  assign ram_read_enable  = rd_en;
  assign ram_read_addr    = rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      count_q     <= '0;
      rd_inflight <= 1'b0;
    end else if (flush) begin
      // Clearing rd_inflight drops the read data that returns next cycle.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      count_q     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (rd_en) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      ram_cnt     <= ram_cnt + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, rd_en};
      count_q     <= count_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
      rd_inflight <= rd_en;
    end
  end

  ram_fifo_outbuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outbuf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_vld   (rd_inflight),
    .wr_dat   (ram_data_out),
    .pop      (pop),
    .out_valid(out_valid),
    .out_data (out_data),
    .occ      (buf_occ)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, queue-based reference model, per-cycle compare.
// Latency: model makes each word visible two edges after its push, back-to-back thereafter.
// Backpressure: model refuses pushes when it holds DEPTH words or flush is high.
module tb_ram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic [AW-1:0] ram_write_addr;
  logic [AW-1:0] ram_read_addr;
  logic          ram_write_enable;
  logic          ram_read_enable;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty),
    .ram_write_addr(ram_write_addr), .ram_read_addr(ram_read_addr),
    .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Synchronous RAM: read data valid the cycle after the strobe is sampled.
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_write_addr] <= ram_data_in;
    if (ram_read_enable)  ram_data_out <= mem[ram_read_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered queue of held words, each tagged with its push edge.
  typedef struct {
    logic [DW-1:0] d;
    int            tag;
  } ent_t;

  ent_t mq[$];
  int   cyc = 0;
  int   wptr_m = 0;
  bit   m_push = 0;
  bit   m_pop = 0;
  bit   e_full, e_rdy, e_ov;

  always @(negedge clk) begin
    m_push = 0;
    m_pop  = 0;
    if (!rst) begin
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_wr_en", 32'(ram_write_enable), 0);
      chk("rst_rd_en", 32'(ram_read_enable), 0);
      chk("rst_wr_addr", 32'(ram_write_addr), 0);
      chk("rst_rd_addr", 32'(ram_read_addr), 0);
    end else begin
      e_full = (mq.size() == DEPTH);
      e_rdy  = !e_full && !flush;
      e_ov   = 0;
      if (mq.size() > 0) e_ov = (mq[0].tag + 2 <= cyc);
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(e_full));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("in_ready", 32'(in_ready), 32'(e_rdy));
      chk("ram_write_enable", 32'(ram_write_enable), 32'(in_valid && e_rdy));
      chk("ram_data_in", 32'(ram_data_in), 32'(in_data));
      chk("ram_write_addr", 32'(ram_write_addr), 32'(wptr_m));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      if (e_ov) chk("out_data", 32'(out_data), 32'(mq[0].d));
      m_push = in_valid && e_rdy;
      m_pop  = e_ov && out_ready;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst || flush) begin
      mq.delete();
      wptr_m = 0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back('{in_data, cyc});
        wptr_m = (wptr_m + 1) % DEPTH;
      end
    end
  end

  // Inputs change 1ns after the rising edge; acc reports whether the word was taken.
  task automatic drive(input bit iv, input logic [DW-1:0] id, input bit ordy, input bit fl,
                       output bit acc);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    acc = iv && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit iv, input logic [DW-1:0] id, input bit ordy, input bit fl);
    bit dummy;
    drive(iv, id, ordy, fl, dummy);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (!empty && guard < 3000) begin
      step(0, '0, 1, 0);
      guard++;
    end
    chk(name, 32'(empty), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    int guard;

    // Reset state
    repeat (3) step(0, '0, 0, 0);
    chk("lit_rst_count", 32'(count), 0);
    chk("lit_rst_empty", 32'(empty), 1);
    chk("lit_rst_in_ready", 32'(in_ready), 0);
    rst = 1'b1;
    step(0, '0, 1, 0);

    // Single word latency: push at edge N, visible after N+2, gone after N+3
    step(1, 8'hAA, 1, 0);
    chk("lat_count_n", 32'(count), 1);
    chk("lat_ov_n", 32'(out_valid), 0);
    step(0, '0, 1, 0);
    chk("lat_ov_n1", 32'(out_valid), 0);
    step(0, '0, 1, 0);
    chk("lat_ov_n2", 32'(out_valid), 1);
    chk("lat_data_n2", 32'(out_data), 32'h AA);
    step(0, '0, 1, 0);
    chk("lat_count_n3", 32'(count), 0);
    chk("lat_empty_n3", 32'(empty), 1);

    // Flush zeroes the write pointer
    step(0, '0, 0, 1);
    chk("flush_wptr", 32'(ram_write_addr), 0);

    // Fill to DEPTH with output stalled
    for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_count", 32'(count), 1024);
    chk("fill_wptr_wrap", 32'(ram_write_addr), 0);
    chk("fill_head_valid", 32'(out_valid), 1);
    chk("fill_head_data", 32'(out_data), 0);
    drive(1, 8'hEE, 0, 0, acc);
    chk("push_when_full_refused", 32'(acc), 0);
    chk("count_after_refused", 32'(count), 1024);

    // Drain in order, pointers wrap back to 0
    drain("drain_full_empty");
    chk("drain_rptr_wrap", 32'(ram_read_addr), 0);
    chk("drain_wptr_wrap", 32'(ram_write_addr), 0);

    // 3000 words with random input gaps and output stalls
    n = 0;
    guard = 0;
    while (n < 3000 && guard < 20000) begin
      drive(($urandom % 8) != 0, DW'(n * 7 + 3), ($urandom % 3) != 0, 0, acc);
      if (acc) n++;
      guard++;
    end
    chk("random_words_pushed", 32'(n), 3000);
    drain("random_drain_empty");

    // Steady push/pop from empty: three words in flight, out_valid never drops
    for (int i = 0; i < 40; i++) step(1, DW'(8'h80 + i), 1, 0);
    chk("steady_count", 32'(count), 3);
    chk("steady_ov", 32'(out_valid), 1);
    drain("steady_drain_empty");

    // Flush with 5 held and a read in flight; a push during flush is refused
    for (int i = 0; i < 6; i++) step(1, DW'(8'h10 + i), 0, 0);
    step(0, '0, 1, 0);
    chk("preflush_count", 32'(count), 5);
    step(1, 8'h77, 0, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_ov", 32'(out_valid), 0);
    step(1, 8'h55, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    chk("postflush_ov", 32'(out_valid), 1);
    chk("postflush_first", 32'(out_data), 32'h55);
    step(0, '0, 1, 0);
    chk("postflush_empty", 32'(empty), 1);

    // Reset mid-stream with 7 words held
    for (int i = 0; i < 7; i++) step(1, DW'(8'h20 + i), 0, 0);
    chk("prereset_count", 32'(count), 7);
    rst = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_ov", 32'(out_valid), 0);
    chk("midrst_data", 32'(out_data), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_full", 32'(full), 0);
    step(0, '0, 0, 0);
    rst = 1'b1;
    step(1, 8'hC1, 1, 0);
    step(1, 8'hC2, 1, 0);
    step(1, 8'hC3, 1, 0);
    chk("postrst_first", 32'(out_data), 32'hC1);
    chk("postrst_ov", 32'(out_valid), 1);
    drain("postrst_drain_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
